// File: rtl/memo_port_if.sv
// Command/response and RAM-side bus of memo_port, grouped as one interface.
// slave = the sequencer itself, master = surrounding logic plus the memo RAM.
interface memo_port_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [5:0] mem_address;
  logic [7:0] mem_data;
  logic       mem_wren;
  logic [7:0] mem_q;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, mem_q,
    output cmd_ready, rsp_valid, rsp_data, mem_address, mem_data, mem_wren
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, mem_q,
    input  cmd_ready, rsp_valid, rsp_data, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/memo_port.sv
// Command sequencer in front of the 64x8 synchronous-read memo RAM.
// Optional feature: MEMO_PORT_SUM_EN enables the sum command (op 11).
module memo_port (
  input  logic         clock,
  input  logic         reset,
  memo_port_if.slave   bus
);

`ifdef MEMO_PORT_SUM_EN
  typedef enum logic [2:0] {
    IDLE, WRITE, RD_WAIT, RD_CAP, FILL, SUM_RUN, SUM_DRAIN
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WRITE, RD_WAIT, RD_CAP, FILL, NOP_RSP
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       wren_q, wren_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
`ifdef MEMO_PORT_SUM_EN
  logic [7:0] acc_q, acc_d;
`endif

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_wren    = wren_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 6'd0;
      data_q      <= 8'd0;
      wren_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
`ifdef MEMO_PORT_SUM_EN
      acc_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef MEMO_PORT_SUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  // Command inputs are looked at only in IDLE, so anything presented while busy is dropped.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wren_d      = wren_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`ifdef MEMO_PORT_SUM_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            2'b00: begin
              addr_d  = bus.cmd_addr;
              data_d  = bus.cmd_data;
              wren_d  = 1'b1;
              state_d = WRITE;
            end
            2'b01: begin
              addr_d  = bus.cmd_addr;
              wren_d  = 1'b0;
              state_d = RD_WAIT;
            end
            2'b10: begin
              addr_d  = 6'd0;
              data_d  = bus.cmd_data;
              wren_d  = 1'b1;
              state_d = FILL;
            end
            default: begin
`ifdef MEMO_PORT_SUM_EN
              addr_d  = 6'd0;
              wren_d  = 1'b0;
              acc_d   = 8'd0;
              state_d = SUM_RUN;
`else
              state_d = NOP_RSP;
`endif
            end
          endcase
        end
      end
      WRITE: begin
        wren_d      = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        rsp_data_d  = bus.mem_q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      // The last word (63) is written on the same edge that wraps the address back to 0.
      FILL: begin
        if (addr_q == 6'd63) begin
          addr_d      = 6'd0;
          wren_d      = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          addr_d = addr_q + 6'd1;
        end
      end
`ifdef MEMO_PORT_SUM_EN
      // mem_q trails the address by one edge, so word N is added while the address shows N+1.
      SUM_RUN: begin
        if (addr_q != 6'd0) acc_d = acc_q + bus.mem_q;
        if (addr_q == 6'd63) begin
          addr_d  = 6'd0;
          state_d = SUM_DRAIN;
        end else begin
          addr_d = addr_q + 6'd1;
        end
      end
      SUM_DRAIN: begin
        rsp_data_d  = acc_q + bus.mem_q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
`else
      NOP_RSP: begin
        rsp_data_d  = 8'd0;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memo_port.sv
// Directed bench for memo_port with a behavioural 64x8 synchronous-read RAM model.
// Honours MEMO_PORT_SUM_EN to select the expected op-11 behaviour.
module tb_memo_port;
  logic clock;
  logic reset;
  logic ramLoad;
  logic [7:0] ram [64];
  int errors;
  int checks;
  int lat;
  int wc;
  int pulses;

  memo_port_if bus ();

  memo_port dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // RAM model: write on wren, registered read of the pre-write contents
  always @(posedge clock) begin
    if (ramLoad) begin
      for (int i = 0; i < 64; i++) ram[i] <= 8'(i);
      bus.mem_q <= 8'd0;
    end else begin
      if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
      bus.mem_q <= ram[bus.mem_address];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one command for exactly the acceptance edge; returns just after E0
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Edges from E0 to the response, plus the number of sampled cycles with wren high
  task automatic waitRsp(output int latency, output int wrenCount);
    latency = 0;
    wrenCount = bus.mem_wren ? 1 : 0;
    while (!bus.rsp_valid && latency < 200) begin
      tick();
      latency++;
      if (bus.mem_wren) wrenCount++;
    end
  endtask

  task automatic readWord(input string tag, input logic [5:0] addr, input logic [7:0] expected);
    applyStimulus(2'b01, addr, 8'h00);
    waitRsp(lat, wc);
    checkOutput({tag, "_lat"}, 32'(lat), 32'd2);
    checkOutput({tag, "_data"}, 32'(bus.rsp_data), 32'(expected));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clock = 1'b0;
    reset = 1'b1;
    ramLoad = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_addr = 6'd0;
    bus.cmd_data = 8'd0;

    repeat (3) tick();
    reset = 1'b0;
    ramLoad = 1'b0;
    checkOutput("rst_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_wren", 32'(bus.mem_wren), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    checkOutput("rst_address", 32'(bus.mem_address), 32'd0);

    $display("[TB] write 0x05 <- 0x3C then read back");
    applyStimulus(2'b00, 6'h05, 8'h3C);
    checkOutput("wr_busy", 32'(bus.cmd_ready), 32'd0);
    waitRsp(lat, wc);
    checkOutput("wr_lat", 32'(lat), 32'd1);
    checkOutput("wr_wren_cycles", 32'(wc), 32'd1);
    checkOutput("wr_rsp_data_held", 32'(bus.rsp_data), 32'd0);
    checkOutput("wr_ready_with_rsp", 32'(bus.cmd_ready), 32'd1);
    tick();
    checkOutput("wr_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    readWord("rd_05", 6'h05, 8'h3C);

    $display("[TB] reset in the middle of a fill with 0x77");
    applyStimulus(2'b10, 6'h00, 8'h77);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_wren", 32'(bus.mem_wren), 32'd0);
    checkOutput("mid_rst_address", 32'(bus.mem_address), 32'd0);
    checkOutput("mid_rst_mem_data", 32'(bus.mem_data), 32'd0);
    checkOutput("mid_rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    checkOutput("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    readWord("mid_rst_rd_10", 6'h10, 8'h77);
    readWord("mid_rst_rd_30", 6'h30, 8'h30);

    $display("[TB] full fill with 0xAA");
    applyStimulus(2'b10, 6'h00, 8'hAA);
    waitRsp(lat, wc);
    checkOutput("fill_lat", 32'(lat), 32'd64);
    checkOutput("fill_wren_cycles", 32'(wc), 32'd64);
    checkOutput("fill_addr_rest", 32'(bus.mem_address), 32'd0);
    tick();
    checkOutput("fill_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    readWord("fill_rd_00", 6'h00, 8'hAA);
    readWord("fill_rd_30", 6'h30, 8'hAA);
    readWord("fill_rd_3f", 6'h3F, 8'hAA);

`ifdef MEMO_PORT_SUM_EN
    $display("[TB] sum after fill 0x01 and fill 0x05");
    applyStimulus(2'b10, 6'h00, 8'h01);
    waitRsp(lat, wc);
    applyStimulus(2'b11, 6'h00, 8'h00);
    waitRsp(lat, wc);
    checkOutput("sum1_lat", 32'(lat), 32'd65);
    checkOutput("sum1_wren_cycles", 32'(wc), 32'd0);
    checkOutput("sum1_data", 32'(bus.rsp_data), 32'h40);
    applyStimulus(2'b10, 6'h00, 8'h05);
    waitRsp(lat, wc);
    applyStimulus(2'b11, 6'h00, 8'h00);
    waitRsp(lat, wc);
    checkOutput("sum5_lat", 32'(lat), 32'd65);
    checkOutput("sum5_data", 32'(bus.rsp_data), 32'h40);
`else
    $display("[TB] op 11 without sum support acts as a no-op");
    applyStimulus(2'b11, 6'h00, 8'h00);
    waitRsp(lat, wc);
    checkOutput("nop_lat", 32'(lat), 32'd1);
    checkOutput("nop_wren_cycles", 32'(wc), 32'd0);
    checkOutput("nop_data", 32'(bus.rsp_data), 32'h00);
    readWord("nop_rd_00", 6'h00, 8'hAA);
`endif

    $display("[TB] back-to-back write 0x3F <- 0x11 then read 0x3F");
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 6'h3F;
    bus.cmd_data  = 8'h11;
    tick();
    waitRsp(lat, wc);
    checkOutput("b2b_wr_lat", 32'(lat), 32'd1);
    checkOutput("b2b_ready_in_rsp", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op = 2'b01;
    tick();
    bus.cmd_valid = 1'b0;
    checkOutput("b2b_rd_accepted", 32'(bus.cmd_ready), 32'd0);
    waitRsp(lat, wc);
    checkOutput("b2b_rd_lat", 32'(lat), 32'd2);
    checkOutput("b2b_rd_data", 32'(bus.rsp_data), 32'h11);
    tick();

    $display("[TB] write presented while a read waits on the RAM");
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_addr  = 6'h3F;
    tick();
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h99;
    wc = 0;
    pulses = 0;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid) pulses++;
      if (bus.mem_wren) wc++;
      tick();
    end
    checkOutput("busy_pulses", 32'(pulses), 32'd1);
    checkOutput("busy_wren_cycles", 32'(wc), 32'd0);
    checkOutput("busy_rd_data", 32'(bus.rsp_data), 32'h11);
    readWord("busy_rd_3f", 6'h3F, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
